regfile_dump_reader: RTL and testbench

- Debug-side reader for the 32x32 register file: walks a range of register addresses on one read port, captures each value, and streams (address, data) words out over a valid/ready handshake.
- Sits beside the core's register file, attached to a spare combinational read port (address out, data in).
- Feeds a debug/display path, e.g. a serializer or LED/7-seg scanner.

---
 rtl/regfile_dump_reader.sv | 117 +++++++++++
 tb/tb_regfile_dump_reader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register-file address range and streams (address, data) words
module regfile_dump_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic              valid_nx, last_nx, done_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] data_nx;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            ptr       <= FIRST_A;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            out_valid <= valid_nx;
            out_addr  <= addr_nx;
            out_data  <= data_nx;
            out_last  <= last_nx;
            done      <= done_nx;
        end
    end

    // The pointer only advances on a non-last handshake, so it can never wrap past LAST_REG.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        valid_nx = out_valid;
        addr_nx  = out_addr;
        data_nx  = out_data;
        last_nx  = out_last;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = FETCH;
                    ptr_nx   = FIRST_A;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                end else begin
                    state_nx = SEND;
                    valid_nx = 1'b1;
                    addr_nx  = ptr;
                    data_nx  = rd_data;
                    last_nx  = (ptr == LAST_A);
                end
            end
            SEND: begin
                // Abort wins over a same-cycle handshake; that word is dropped.
                if (abort) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                end else if (out_ready) begin
                    valid_nx = 1'b0;
                    if (out_last) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = FETCH;
                        ptr_nx   = ptr + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign rd_addr = (state == FETCH) ? ptr : FIRST_A;
    assign busy    = (state == FETCH) || (state == SEND);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - scoreboard bench for regfile_dump_reader
module tb_regfile_dump_reader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [4:0]  rd_addr, out_addr;
    logic [31:0] rd_data, out_data;
    logic        out_valid, out_last, busy, done;

    logic        start_n = 1'b0, abort_n = 1'b0, out_ready_n = 1'b0;
    logic [4:0]  rd_addr_n, out_addr_n;
    logic [31:0] rd_data_n, out_data_n;
    logic        out_valid_n, out_last_n, busy_n, done_n;

    logic [31:0] regs [32];

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } word_t;

    word_t sb[$];
    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    assign rd_data   = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];
    assign rd_data_n = (rd_addr_n == 5'd0) ? 32'd0 : regs[rd_addr_n];

    regfile_dump_reader dut (
        .Clk(Clk), .Rst(Rst), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    regfile_dump_reader #(.FIRST_REG(10), .LAST_REG(10)) dut_n (
        .Clk(Clk), .Rst(Rst), .start(start_n), .abort(abort_n),
        .rd_addr(rd_addr_n), .rd_data(rd_data_n),
        .out_valid(out_valid_n), .out_ready(out_ready_n), .out_addr(out_addr_n),
        .out_data(out_data_n), .out_last(out_last_n), .busy(busy_n), .done(done_n)
    );

    task automatic push_dump();
        for (int i = 0; i < 32; i++)
            sb.push_back(word_t'({5'(i), (i == 0) ? 32'd0 : regs[i], (i == 31)}));
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
    endtask

    // Runs one dump from the first FETCH cycle; stop_idx >= 0 aborts or resets while that word is offered.
    task automatic drain(input int mode, input int write_idx, input int stop_idx, input bit stop_reset,
                         input bit noise, output int accepted, output int done_cyc);
        word_t cur, prev, exp;
        bit held, rdy, written;
        int phase;
        accepted = 0; done_cyc = -1; held = 0; phase = 0; written = 0; prev = '0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge Clk);
            cur = {out_addr, out_data, out_last};
            if (done) begin
                done_cyc = cyc;
                checks++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL done_state busy=%b valid=%b required 0 0", busy, out_valid);
                end
                start = 1'b0; out_ready = 1'b0;
                return;
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== prev) begin
                    errors++;
                    $display("FAIL hold valid=%b word=%h required 1 %h", out_valid, cur, prev);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_during_dump busy=%b required 1 at cycle %0d", busy, cyc);
                start = 1'b0; out_ready = 1'b0;
                return;
            end
            if (noise) start = 1'($urandom_range(0, 1));
            rdy = (mode == 0) ? 1'b1 : (phase == 2);
            phase = (phase + 1) % 3;
            out_ready = rdy;
            if (out_valid && write_idx >= 0 && !written && out_addr == 5'(write_idx)) begin
                regs[write_idx] = 32'hDEAD_BEEF;
                written = 1;
            end
            if (out_valid && stop_idx >= 0 && accepted == stop_idx) begin
                if (stop_reset) Rst = 1'b1;
                else begin
                    abort = 1'b1;
                    out_ready = 1'b1;
                end
                @(posedge Clk);
                #1;
                Rst = 1'b0; abort = 1'b0; start = 1'b0; out_ready = 1'b0;
                return;
            end
            if (out_valid && rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word got %h required none", cur);
                end else begin
                    exp = sb.pop_front();
                    if (cur !== exp) begin
                        errors++;
                        $display("FAIL word got %h required %h", cur, exp);
                    end
                end
                accepted++;
            end
            held = out_valid && !rdy;
            prev = cur;
        end
        checks++;
        errors++;
        $display("FAIL dump_timeout accepted=%0d required completion", accepted);
        start = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({out_valid, out_addr, out_data, out_last, busy, done, rd_addr} !== 42'd0) begin
            errors++;
            $display("FAIL reset v=%b a=%h d=%h l=%b b=%b dn=%b ra=%h required all 0",
                     out_valid, out_addr, out_data, out_last, busy, done, rd_addr);
        end
        checks++;
        if (rd_addr_n !== 5'd10 || out_valid_n !== 1'b0 || busy_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_narrow ra=%0d v=%b b=%b required 10 0 0", rd_addr_n, out_valid_n, busy_n);
        end
        Rst = 1'b0;
    endtask

    task automatic test_full_dump();
        int acc, dc;
        push_dump();
        pulse_start();
        drain(0, -1, -1, 0, 0, acc, dc);
        checks++;
        if (acc !== 32 || dc !== 65) begin
            errors++;
            $display("FAIL full_dump words=%0d done_cycle=%0d required 32 65", acc, dc);
        end
        start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done busy=%b done=%b required 0 0", busy, done);
        end
        sb.delete();
    endtask

    task automatic test_backpressure();
        int acc, dc;
        push_dump();
        pulse_start();
        drain(1, -1, -1, 0, 0, acc, dc);
        checks++;
        if (acc !== 32 || dc < 0 || sb.size() !== 0) begin
            errors++;
            $display("FAIL backpressure words=%0d done_cycle=%0d left=%0d required 32 done 0",
                     acc, dc, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_concurrent_write();
        int acc, dc;
        push_dump();
        pulse_start();
        drain(0, 5, -1, 0, 0, acc, dc);
        checks++;
        if (acc !== 32 || regs[5] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_dump words=%0d x5=%h required 32 deadbeef", acc, regs[5]);
        end
        sb.delete();
        push_dump();
        pulse_start();
        drain(0, -1, -1, 0, 0, acc, dc);
        checks++;
        if (acc !== 32 || dc !== 65) begin
            errors++;
            $display("FAIL second_dump words=%0d done_cycle=%0d required 32 65", acc, dc);
        end
        sb.delete();
    endtask

    task automatic test_abort();
        int acc, dc;
        push_dump();
        pulse_start();
        drain(0, -1, 7, 0, 0, acc, dc);
        checks++;
        if (acc !== 7 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL abort words=%0d v=%b b=%b dn=%b l=%b required 7 0 0 0 0",
                     acc, out_valid, busy, done, out_last);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle done=%b busy=%b required 0 0", done, busy);
            end
        end
        sb.delete();
        push_dump();
        pulse_start();
        drain(0, -1, -1, 0, 0, acc, dc);
        checks++;
        if (acc !== 32 || dc !== 65) begin
            errors++;
            $display("FAIL restart words=%0d done_cycle=%0d required 32 65", acc, dc);
        end
        sb.delete();
    endtask

    task automatic test_idle_abort_start();
        @(negedge Clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rd_addr !== 5'd0) begin
            errors++;
            $display("FAIL idle_abort_start busy=%b ra=%0d required 0 0", busy, rd_addr);
        end
    endtask

    task automatic test_reset_mid_dump();
        int acc, dc;
        push_dump();
        pulse_start();
        drain(0, -1, 12, 1, 1, acc, dc);
        checks++;
        if (acc !== 12) begin
            errors++;
            $display("FAIL reset_mid_words words=%0d required 12", acc);
        end
        checks++;
        if ({out_valid, out_addr, out_data, out_last, busy, done, rd_addr} !== 42'd0) begin
            errors++;
            $display("FAIL reset_mid v=%b a=%h d=%h l=%b b=%b dn=%b ra=%h required all 0",
                     out_valid, out_addr, out_data, out_last, busy, done, rd_addr);
        end
        sb.delete();
    endtask

    task automatic test_narrow();
        word_t exp, cur;
        sb.push_back(word_t'({5'd10, regs[10], 1'b1}));
        @(negedge Clk);
        start_n = 1'b1;
        @(posedge Clk);
        #1 start_n = 1'b0;
        @(negedge Clk);
        checks++;
        if (rd_addr_n !== 5'd10 || out_valid_n !== 1'b0 || busy_n !== 1'b1) begin
            errors++;
            $display("FAIL narrow_fetch ra=%0d v=%b b=%b required 10 0 1", rd_addr_n, out_valid_n, busy_n);
        end
        @(negedge Clk);
        out_ready_n = 1'b1;
        cur = {out_addr_n, out_data_n, out_last_n};
        exp = sb.pop_front();
        checks++;
        if (out_valid_n !== 1'b1 || cur !== exp) begin
            errors++;
            $display("FAIL narrow_word v=%b word=%h required 1 %h", out_valid_n, cur, exp);
        end
        @(negedge Clk);
        out_ready_n = 1'b0;
        checks++;
        if (done_n !== 1'b1 || busy_n !== 1'b0 || out_valid_n !== 1'b0) begin
            errors++;
            $display("FAIL narrow_done dn=%b b=%b v=%b required 1 0 0", done_n, busy_n, out_valid_n);
        end
        @(negedge Clk);
        checks++;
        if (done_n !== 1'b0) begin
            errors++;
            $display("FAIL narrow_done_pulse dn=%b required 0", done_n);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[2]  = 32'd1024;
        regs[10] = 32'h0000_002A;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_concurrent_write();
        test_abort();
        test_idle_abort_start();
        test_reset_mid_dump();
        test_narrow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
